// File: rtl/hwpe_ctrl_job_offloader.sv
// Sequencer that offloads one job at a time to an HWPE through its peripheral register-file port.
// Define HWPE_CTRL_OFFLOADER_POLL_EN to detect completion by polling STATUS instead of using evt_i.
module hwpe_ctrl_job_offloader #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned N_JOB_REGS   = 8,
  parameter int unsigned RETRY_CYCLES = 16,
  parameter int unsigned MAX_RETRY    = 255,
  parameter int unsigned ID_WIDTH     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [$clog2(N_JOB_REGS+1)-1:0]    job_nb_regs_i,
  input  logic [N_JOB_REGS*32-1:0]           job_regs_i,
  input  logic                               evt_i,
  output logic                               periph_req_o,
  input  logic                               periph_gnt_i,
  output logic [31:0]                        periph_add_o,
  output logic                               periph_wen_o,
  output logic [3:0]                         periph_be_o,
  output logic [31:0]                        periph_data_o,
  output logic [ID_WIDTH-1:0]                periph_id_o,
  input  logic [31:0]                        periph_r_data_i,
  input  logic                               periph_r_valid_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [7:0]                         done_id_o,
  output logic                               err_o
);

  localparam int unsigned NbW = $clog2(N_JOB_REGS + 1);
  localparam logic [31:0] OfsTrigger = 32'h00;
  localparam logic [31:0] OfsAcquire = 32'h04;
  localparam logic [31:0] OfsStatus  = 32'h0C;
  localparam logic [31:0] OfsRegs    = 32'h20;

  typedef enum logic [3:0] {
    StIdle, StAcq, StBackoff, StWrite, StTrig, StWait, StPollWait, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d, wen_q, wen_d, rd_pend_q, rd_pend_d;
  logic [31:0]             add_q, add_d, data_q, data_d;
  logic [3:0]              be_q, be_d;
  logic [NbW-1:0]          idx_q, idx_d, nb_q, nb_d;
  logic [31:0]             cnt_q, cnt_d, retry_q, retry_d;
  logic [7:0]              job_id_q, job_id_d, done_id_q, done_id_d;
  logic                    err_q, err_d, evt_seen_q, evt_seen_d;
  logic [N_JOB_REGS*32-1:0] regs_q, regs_d;
  logic [31:0]             cur_reg;

  assign cur_reg = regs_q[32*idx_q +: 32];

`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
  logic unused_evt;
  assign unused_evt = evt_i;
`else
  logic unused_rdata;
  assign unused_rdata = ^periph_r_data_i[30:8];
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    add_d      = add_q;
    wen_d      = wen_q;
    be_d       = be_q;
    data_d     = data_q;
    rd_pend_d  = rd_pend_q;
    idx_d      = idx_q;
    nb_d       = nb_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    job_id_d   = job_id_q;
    done_id_d  = done_id_q;
    err_d      = 1'b0;
    evt_seen_d = evt_seen_q;
    regs_d     = regs_q;
    job_ready_o = (state_q == StIdle) && !rst_i;

`ifndef HWPE_CTRL_OFFLOADER_POLL_EN
    // An event during the trigger handshake must not be lost.
    if (evt_i && (state_q == StTrig || state_q == StWait)) evt_seen_d = 1'b1;
`endif

    unique case (state_q)
      StIdle: begin
        if (job_valid_i && job_ready_o) begin
          regs_d  = job_regs_i;
          nb_d    = (job_nb_regs_i > NbW'(N_JOB_REGS)) ? NbW'(N_JOB_REGS) : job_nb_regs_i;
          retry_d = '0;
          state_d = StAcq;
        end
      end
      StAcq: begin
        if (!req_q && !rd_pend_q) begin
          req_d  = 1'b1;
          add_d  = BASE_ADDR + OfsAcquire;
          wen_d  = 1'b1;
          be_d   = 4'hF;
          data_d = '0;
        end else if (req_q && periph_gnt_i) begin
          req_d     = 1'b0;
          rd_pend_d = 1'b1;
        end else if (rd_pend_q && periph_r_valid_i) begin
          rd_pend_d = 1'b0;
          if (periph_r_data_i[31]) begin
            retry_d = retry_q + 32'd1;
            cnt_d   = '0;
            if (MAX_RETRY != 0 && retry_d == MAX_RETRY) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StBackoff;
            end
          end else begin
            job_id_d = periph_r_data_i[7:0];
            idx_d    = '0;
            state_d  = (nb_q == '0) ? StTrig : StWrite;
          end
        end
      end
      StBackoff: begin
        if (cnt_q == RETRY_CYCLES - 1) state_d = StAcq;
        else cnt_d = cnt_q + 32'd1;
      end
      StWrite: begin
        if (!req_q) begin
          req_d  = 1'b1;
          add_d  = BASE_ADDR + OfsRegs + (32'(idx_q) << 2);
          wen_d  = 1'b0;
          be_d   = 4'hF;
          data_d = cur_reg;
        end else if (periph_gnt_i) begin
          req_d = 1'b0;
          if (idx_q == nb_q - NbW'(1)) state_d = StTrig;
          else idx_d = idx_q + NbW'(1);
        end
      end
      StTrig: begin
        if (!req_q) begin
          req_d  = 1'b1;
          add_d  = BASE_ADDR + OfsTrigger;
          wen_d  = 1'b0;
          be_d   = 4'hF;
          data_d = '0;
        end else if (periph_gnt_i) begin
          req_d   = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
        if (!req_q && !rd_pend_q) begin
          req_d  = 1'b1;
          add_d  = BASE_ADDR + OfsStatus;
          wen_d  = 1'b1;
          be_d   = 4'hF;
          data_d = '0;
        end else if (req_q && periph_gnt_i) begin
          req_d     = 1'b0;
          rd_pend_d = 1'b1;
        end else if (rd_pend_q && periph_r_valid_i) begin
          rd_pend_d = 1'b0;
          if (periph_r_data_i == '0) begin
            done_id_d = job_id_q;
            state_d   = StDone;
          end else begin
            cnt_d   = '0;
            state_d = StPollWait;
          end
        end
`else
        if (evt_seen_q) begin
          done_id_d = job_id_q;
          state_d   = StDone;
        end
`endif
      end
      StPollWait: begin
        if (cnt_q == RETRY_CYCLES - 1) state_d = StWait;
        else cnt_d = cnt_q + 32'd1;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle && state_q != StIdle) evt_seen_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      add_q      <= '0;
      wen_q      <= 1'b1;
      be_q       <= '0;
      data_q     <= '0;
      rd_pend_q  <= 1'b0;
      idx_q      <= '0;
      nb_q       <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
      job_id_q   <= '0;
      done_id_q  <= '0;
      err_q      <= 1'b0;
      evt_seen_q <= 1'b0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      add_q      <= add_d;
      wen_q      <= wen_d;
      be_q       <= be_d;
      data_q     <= data_d;
      rd_pend_q  <= rd_pend_d;
      idx_q      <= idx_d;
      nb_q       <= nb_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      job_id_q   <= job_id_d;
      done_id_q  <= done_id_d;
      err_q      <= err_d;
      evt_seen_q <= evt_seen_d;
      regs_q     <= regs_d;
    end
  end

  assign periph_req_o  = req_q;
  assign periph_add_o  = add_q;
  assign periph_wen_o  = wen_q;
  assign periph_be_o   = be_q;
  assign periph_data_o = data_q;
  assign periph_id_o   = '0;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign done_id_o     = done_id_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_offloader.sv
// Randomized bench for hwpe_ctrl_job_offloader: a bus-slave model logs every granted access and the
// expected access list for each job is derived from the job descriptor and the ACQUIRE answers.
module tb_hwpe_ctrl_job_offloader;

  localparam logic [31:0] BASE = 32'h1A10_0000;
  localparam int N   = 8;
  localparam int RC  = 4;
  localparam int MR  = 3;
  localparam int IDW = 8;
  localparam int NBW = $clog2(N + 1);
  localparam logic [31:0] A_TRIG = BASE;
  localparam logic [31:0] A_ACQ  = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [NBW-1:0]   job_nb;
  logic [N*32-1:0]  job_regs;
  logic             evt;
  logic             req, gnt, wen, rvalid, busy, done, err;
  logic [31:0]      add, wdata, rdata;
  logic [3:0]       be;
  logic [IDW-1:0]   pid;
  logic [7:0]       done_id;

  hwpe_ctrl_job_offloader #(
    .BASE_ADDR   (BASE),
    .N_JOB_REGS  (N),
    .RETRY_CYCLES(RC),
    .MAX_RETRY   (MR),
    .ID_WIDTH    (IDW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .job_valid_i     (job_valid),
    .job_ready_o     (job_ready),
    .job_nb_regs_i   (job_nb),
    .job_regs_i      (job_regs),
    .evt_i           (evt),
    .periph_req_o    (req),
    .periph_gnt_i    (gnt),
    .periph_add_o    (add),
    .periph_wen_o    (wen),
    .periph_be_o     (be),
    .periph_data_o   (wdata),
    .periph_id_o     (pid),
    .periph_r_data_i (rdata),
    .periph_r_valid_i(rvalid),
    .busy_o          (busy),
    .done_o          (done),
    .done_id_o       (done_id),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
  } acc_t;

  acc_t        log_q[$];
  int          log_cyc[$];
  acc_t        exp_q[$];
  logic [31:0] acq_q[$];
  logic [31:0] status_q[$];
  logic [31:0] jregs [N];
  bit          exp_err;
  logic [7:0]  exp_id;
  logic [7:0]  last_id;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Slave-model state
  int          stall, rd_wait, evt_wait, stab_viol, req_viol;
  int          evt_force = -1;
  bit          in_req;
  acc_t        cur;
  logic [31:0] stall_add = 32'h0;
  logic [31:0] rd_pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus slave: random grant stalls, read answers 1..3 cycles after the grant, stray r_valid pulses.
  always @(negedge clk) begin
    if (rst) begin
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; evt = 1'b0;
      in_req = 1'b0; stall = 0; rd_wait = 0; evt_wait = 0;
    end else begin
      rvalid = 1'b0;
      evt    = 1'b0;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin rvalid = 1'b1; rdata = rd_pend; end
      end else if ($urandom_range(0, 7) == 0) begin
        rvalid = 1'b1;
        rdata  = $urandom;
      end
      if (evt_wait > 0) begin
        evt_wait--;
        if (evt_wait == 0) evt = 1'b1;
      end
      if (gnt) begin
        gnt    = 1'b0;
        in_req = 1'b0;
        if (req) req_viol++;
      end else if (req) begin
        if (be !== 4'hF) stab_viol++;
        if (!in_req) begin
          in_req = 1'b1;
          cur    = '{add, wen, wdata};
          stall  = (add == stall_add) ? 7 : $urandom_range(0, 3);
        end else if (add !== cur.add || wen !== cur.wen || wdata !== cur.data) begin
          stab_viol++;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          gnt = 1'b1;
          log_q.push_back(cur);
          log_cyc.push_back(cyc);
          if (cur.wen) begin
            if (cur.add == A_ACQ) rd_pend = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
            else if (cur.add == A_STAT)
              rd_pend = (status_q.size() > 0) ? status_q.pop_front() : 32'h0;
            else rd_pend = 32'hDEAD_BEEF;
            rd_wait = $urandom_range(1, 3);
          end else if (cur.add == A_TRIG) begin
            int ew;
            ew = (evt_force >= 0) ? evt_force : $urandom_range(0, 4);
            if (ew == 0) evt = 1'b1;
            else evt_wait = ew;
          end
        end
      end
    end
  end

  // Reference: the access list a job must produce, from its descriptor and the bus answers.
  function automatic void build_model(input int nb);
    int n;
    exp_q.delete();
    exp_err = 1'b0;
    exp_id  = '0;
    n = (nb > N) ? N : nb;
    for (int k = 0; k < acq_q.size(); k++) begin
      exp_q.push_back('{A_ACQ, 1'b1, 32'h0});
      if (!acq_q[k][31]) begin exp_id = acq_q[k][7:0]; break; end
      if (k + 1 == MR) begin exp_err = 1'b1; break; end
    end
    if (!exp_err) begin
      for (int i = 0; i < n; i++) exp_q.push_back('{BASE + 32'h20 + 32'(4 * i), 1'b0, jregs[i]});
      exp_q.push_back('{A_TRIG, 1'b0, 32'h0});
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
      for (int k = 0; k < status_q.size(); k++) begin
        exp_q.push_back('{A_STAT, 1'b1, 32'h0});
        if (status_q[k] == 0) break;
      end
`endif
    end
  endfunction

  task automatic load_status();
    status_q.delete();
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    repeat ($urandom_range(0, 2)) status_q.push_back(32'($urandom_range(1, 255)));
    status_q.push_back(32'h0);
`endif
  endtask

  task automatic start_job(input int nb);
    int t;
    build_model(nb);
    log_q.delete();
    log_cyc.delete();
    stab_viol = 0;
    req_viol  = 0;
    for (int i = 0; i < N; i++) job_regs[32*i +: 32] = jregs[i];
    job_nb    = NBW'(nb);
    job_valid = 1'b1;
    t = 0;
    while (!job_ready && t < 200) begin @(negedge clk); t++; end
    check_eq("accept_in_time", 32'(t < 200), 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int t, nd, ne, gaps;
    logic [7:0] id;
    nd = 0; ne = 0; id = '0; t = 0; gaps = 0;
    check_eq({tag, ":busy"}, 32'(busy), 32'd1);
    while (nd == 0 && ne == 0 && t < 3000) begin
      @(negedge clk);
      t++;
      if (done) begin nd++; id = done_id; end
      if (err) ne++;
    end
    check_eq({tag, ":finish_in_time"}, 32'(t < 3000), 32'd1);
    @(negedge clk);
    if (done) nd++;
    if (err) ne++;
    check_eq({tag, ":ready_after"}, 32'(job_ready), 32'd1);
    check_eq({tag, ":busy_after"}, 32'(busy), 32'd0);
    check_eq({tag, ":done_pulses"}, 32'(nd), 32'(!exp_err));
    check_eq({tag, ":err_pulses"}, 32'(ne), 32'(exp_err));
    if (!exp_err) begin
      check_eq({tag, ":done_id"}, 32'(id), 32'(exp_id));
      last_id = exp_id;
    end
    check_eq({tag, ":done_id_held"}, 32'(done_id), 32'(last_id));
    check_eq({tag, ":n_access"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      check_eq({tag, ":addr"}, log_q[k].add, exp_q[k].add);
      check_eq({tag, ":wen"}, 32'(log_q[k].wen), 32'(exp_q[k].wen));
      if (!exp_q[k].wen) check_eq({tag, ":wdata"}, log_q[k].data, exp_q[k].data);
    end
    for (int k = 1; k < log_q.size(); k++)
      if (log_q[k].add == A_ACQ && log_q[k-1].add == A_ACQ && log_cyc[k] - log_cyc[k-1] < RC)
        gaps++;
    check_eq({tag, ":retry_spacing"}, 32'(gaps), 32'd0);
    check_eq({tag, ":stable_while_stalled"}, 32'(stab_viol), 32'd0);
    check_eq({tag, ":req_drop_after_gnt"}, 32'(req_viol), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int t, nl;
    rst = 1'b1; job_valid = 1'b0; job_nb = '0; job_regs = '0; last_id = '0;
    repeat (3) @(negedge clk);
    check_eq("rst:ready", 32'(job_ready), 32'd0);
    check_eq("rst:req", 32'(req), 32'd0);
    check_eq("rst:add", add, 32'h0);
    check_eq("rst:wen", 32'(wen), 32'd1);
    check_eq("rst:be", 32'(be), 32'd0);
    check_eq("rst:data", wdata, 32'h0);
    check_eq("rst:id", 32'(pid), 32'd0);
    check_eq("rst:busy", 32'(busy), 32'd0);
    check_eq("rst:done", 32'(done), 32'd0);
    check_eq("rst:done_id", 32'(done_id), 32'd0);
    check_eq("rst:err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle:ready", 32'(job_ready), 32'd1);

    // Basic three-register job
    jregs[0] = 32'hAAAA_0001; jregs[1] = 32'hBBBB_0002; jregs[2] = 32'hCCCC_0003;
    acq_q = {32'h5};
    load_status();
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    status_q = {32'h1, 32'h1, 32'h0};
`endif
    start_job(3); finish_job("basic");

    // Locked twice, then granted context 2
    acq_q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2};
    load_status(); start_job(2); finish_job("locked");

    // Always locked: job dropped at the retry limit
    acq_q = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    load_status(); start_job(4); finish_job("retry_limit");

    // Long grant stall on job register 2
    for (int i = 0; i < N; i++) jregs[i] = $urandom;
    stall_add = BASE + 32'h28;
    acq_q = {32'h11};
    load_status(); start_job(4); finish_job("gnt_stall");
    stall_add = 32'h0;

    // Event during the trigger grant cycle, no job registers
    evt_force = 0;
    acq_q = {32'h22};
    load_status(); start_job(0); finish_job("early_evt");
    evt_force = -1;

    // Register count above N_JOB_REGS is clamped
    acq_q = {32'h33};
    load_status(); start_job(13); finish_job("clamp");

    // Reset in the middle of the register writes
    acq_q = {32'h7};
    load_status(); start_job(6);
    t = 0;
    while (t < 500) begin
      @(negedge clk);
      t++;
      if (log_q.size() > 0 && !log_q[log_q.size()-1].wen) break;
    end
    check_eq("midrst:reached_write", 32'(t < 500), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst:req", 32'(req), 32'd0);
    check_eq("midrst:busy", 32'(busy), 32'd0);
    check_eq("midrst:ready", 32'(job_ready), 32'd0);
    check_eq("midrst:add", add, 32'h0);
    check_eq("midrst:wen", 32'(wen), 32'd1);
    check_eq("midrst:done_id", 32'(done_id), 32'd0);
    last_id = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    acq_q = {32'h44};
    load_status(); start_job(3); finish_job("after_rst");

    // Random jobs, issued back to back
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < N; i++) jregs[i] = $urandom;
      acq_q.delete();
      nl = $urandom_range(0, 3);
      repeat (nl) acq_q.push_back({1'b1, 31'($urandom)});
      acq_q.push_back({1'b0, 31'($urandom)});
      load_status();
      start_job($urandom_range(0, 15));
      finish_job("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
